tap_controller: RTL and testbench

- IEEE 1149.1-style TAP controller that sequences the boundary-scan chain.
- Decodes TMS into the 16-state TAP state machine and holds the instruction register.
- Drives the chain's ShiftDR/ClockDR/UpdateDR/Mode controls and a 1-bit bypass register, and muxes the serial output onto TDO.
- Sits between the chip-level JTAG pins and the boundary-scan chain.

---
 rtl/tap_pkg.sv | 35 +++
 rtl/tap_if.sv | 26 ++
 rtl/tap_fsm.sv | 43 ++++
 rtl/tap_controller.sv | 139 +++++++++++++
 tb/tb_tap_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, opcodes, IR capture pattern and DR select.
package tap_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_IDLE         = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // Opcode values; BYPASS is all ones at whatever IR width is chosen.
    localparam int OP_EXTEST  = 0;
    localparam int OP_SAMPLE  = 1;
    localparam int OP_IDCODE  = 2;
    localparam int IR_CAPTURE = 5;

    typedef enum logic [1:0] {
        SEL_BSR    = 2'd0,
        SEL_BYPASS = 2'd1,
        SEL_ID     = 2'd2
    } dr_sel_e;

endpackage

// File: rtl/tap_if.sv
// JTAG pin / boundary-scan chain bundle seen by the TAP controller.
interface tap_if #(
    parameter int IR_W = 4
);
    logic            TMS;
    logic            TDI;
    logic            BsrTDO;
    logic            ShiftDR;
    logic            ClockDR;
    logic            UpdateDR;
    logic            Mode;
    logic            TDO;
    logic            TDOEn;
    logic [IR_W-1:0] Instr;
    logic [3:0]      TapState;

    modport master (
        output TMS, TDI, BsrTDO,
        input  ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDOEn, Instr, TapState
    );

    modport slave (
        input  TMS, TDI, BsrTDO,
        output ShiftDR, ClockDR, UpdateDR, Mode, TDO, TDOEn, Instr, TapState
    );
endinterface

// File: rtl/tap_fsm.sv
// 16-state 1149.1 TAP state machine: state register and TMS-driven next-state logic.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       TCK,
    input  logic       Reset,
    input  logic       TMS,
    output tap_state_e TapState
);

    tap_state_e state_q, state_d;

    always_ff @(posedge TCK) begin
        if (Reset) state_q <= TEST_LOGIC_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TEST_LOGIC_RESET: state_d = TMS ? TEST_LOGIC_RESET : RUN_IDLE;
            RUN_IDLE:         state_d = TMS ? SELECT_DR        : RUN_IDLE;
            SELECT_DR:        state_d = TMS ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         state_d = TMS ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         state_d = TMS ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         state_d = TMS ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         state_d = TMS ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        state_d = TMS ? SELECT_DR        : RUN_IDLE;
            SELECT_IR:        state_d = TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         state_d = TMS ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         state_d = TMS ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         state_d = TMS ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         state_d = TMS ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        state_d = TMS ? SELECT_DR        : RUN_IDLE;
            default:          state_d = TEST_LOGIC_RESET;
        endcase
    end

    assign TapState = state_q;

endmodule

// File: rtl/tap_controller.sv
// TAP controller: IR, bypass/ID registers, chain control decode and TDO mux.
// Define TAP_IDCODE_EN to build in the 32-bit ID register (reset instruction becomes IDCODE).
module tap_controller
    import tap_pkg::*;
#(
    parameter int IR_W = 4
`ifdef TAP_IDCODE_EN
    , parameter logic [31:0] IDCODE_VAL = 32'h1234_5077
`endif
) (
    input  logic  TCK,
    input  logic  Reset,
    tap_if.slave  jtag
);

    localparam logic [IR_W-1:0] EXTEST_OP = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] SAMPLE_OP = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] IDCODE_OP = IR_W'(OP_IDCODE);
    localparam logic [IR_W-1:0] BYPASS_OP = '1;
    localparam logic [IR_W-1:0] IR_CAP    = IR_W'(IR_CAPTURE);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_W-1:0] RESET_OP  = IDCODE_OP;
`else
    localparam logic [IR_W-1:0] RESET_OP  = BYPASS_OP;
`endif

    function automatic dr_sel_e decode_instr(input logic [IR_W-1:0] op);
        dr_sel_e sel;
        if (op == EXTEST_OP || op == SAMPLE_OP) sel = SEL_BSR;
`ifdef TAP_IDCODE_EN
        else if (op == IDCODE_OP)               sel = SEL_ID;
`else
        else if (op == IDCODE_OP)               sel = SEL_BYPASS;
`endif
        else                                    sel = SEL_BYPASS;
        return sel;
    endfunction

    tap_state_e      state;
    dr_sel_e         dr_sel;
    logic            bsr_sel;

    logic [IR_W-1:0] ir_sh_q, ir_sh_d;
    logic [IR_W-1:0] instr_q, instr_d;
    logic            mode_q, mode_d;
    logic            bypass_q, bypass_d;
`ifdef TAP_IDCODE_EN
    logic [31:0]     id_sh_q, id_sh_d;
`endif

    tap_fsm u_fsm (
        .TCK      (TCK),
        .Reset    (Reset),
        .TMS      (jtag.TMS),
        .TapState (state)
    );

    assign dr_sel  = decode_instr(instr_q);
    assign bsr_sel = (dr_sel == SEL_BSR);

    always_ff @(posedge TCK) begin
        if (Reset) begin
            ir_sh_q  <= '0;
            instr_q  <= RESET_OP;
            mode_q   <= 1'b0;
            bypass_q <= 1'b0;
`ifdef TAP_IDCODE_EN
            id_sh_q  <= '0;
`endif
        end else begin
            ir_sh_q  <= ir_sh_d;
            instr_q  <= instr_d;
            mode_q   <= mode_d;
            bypass_q <= bypass_d;
`ifdef TAP_IDCODE_EN
            id_sh_q  <= id_sh_d;
`endif
        end
    end

    // Register next-state: all updates keyed off the state being left on this edge.
    always_comb begin
        ir_sh_d  = ir_sh_q;
        instr_d  = instr_q;
        mode_d   = mode_q;
        bypass_d = bypass_q;
`ifdef TAP_IDCODE_EN
        id_sh_d  = id_sh_q;
`endif
        case (state)
            CAPTURE_IR: ir_sh_d = IR_CAP;
            SHIFT_IR:   ir_sh_d = {jtag.TDI, ir_sh_q[IR_W-1:1]};
            default:    ;
        endcase
        if (state == TEST_LOGIC_RESET) begin
            instr_d = RESET_OP;
            mode_d  = 1'b0;
        end else if (state == UPDATE_IR) begin
            instr_d = ir_sh_q;
            mode_d  = (ir_sh_q == EXTEST_OP);
        end
        if (state == CAPTURE_DR) begin
            bypass_d = 1'b0;
`ifdef TAP_IDCODE_EN
            id_sh_d  = IDCODE_VAL;
`endif
        end else if (state == SHIFT_DR) begin
            if (dr_sel == SEL_BYPASS) bypass_d = jtag.TDI;
`ifdef TAP_IDCODE_EN
            if (dr_sel == SEL_ID)     id_sh_d  = {jtag.TDI, id_sh_q[31:1]};
`endif
        end
    end

    // Moore outputs decoded from the registered state and instruction.
    always_comb begin
        jtag.ShiftDR  = bsr_sel && (state == SHIFT_DR);
        jtag.ClockDR  = bsr_sel && (state == SHIFT_DR || state == CAPTURE_DR);
        jtag.UpdateDR = bsr_sel && (state == UPDATE_DR);
        jtag.TDOEn    = (state == SHIFT_DR) || (state == SHIFT_IR);
        jtag.Mode     = mode_q;
        jtag.Instr    = instr_q;
        jtag.TapState = state;
        jtag.TDO      = 1'b0;
        if (state == SHIFT_IR) begin
            jtag.TDO = ir_sh_q[0];
        end else if (state == SHIFT_DR) begin
            case (dr_sel)
                SEL_BSR:    jtag.TDO = jtag.BsrTDO;
                SEL_BYPASS: jtag.TDO = bypass_q;
`ifdef TAP_IDCODE_EN
                SEL_ID:     jtag.TDO = id_sh_q[0];
`endif
                default:    jtag.TDO = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// Directed self-checking bench for tap_controller (honours TAP_IDCODE_EN when defined).
module tb_tap_controller;

`ifdef TAP_IDCODE_EN
    localparam logic [3:0]  RESET_OP = 4'b0010;
    localparam logic [31:0] ID_VAL   = 32'h1234_5077;
`else
    localparam logic [3:0]  RESET_OP = 4'b1111;
`endif

    logic tck = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tap_if #(.IR_W(4)) bus ();

    tap_controller #(.IR_W(4)) dut (
        .TCK   (tck),
        .Reset (rst),
        .jtag  (bus)
    );

    always #5 tck = ~tck;

    task automatic step(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge tck);
        #1;
    endtask

    task automatic go_tlr();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    endtask

    // Enters from Run-Idle and returns to Run-Idle with op loaded.
    task automatic load_ir(input logic [3:0] op);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i]);
        step(1, 0); step(0, 0);
    endtask

    task automatic test_reset();
        checks++; if (bus.TapState !== 4'hF) begin errors++; $display("FAIL por_state got %h want F", bus.TapState); end
        checks++; if (bus.Instr !== RESET_OP) begin errors++; $display("FAIL por_instr got %h want %h", bus.Instr, RESET_OP); end
        checks++; if ({bus.Mode, bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDOEn, bus.TDO} !== 6'b0) begin
            errors++; $display("FAIL por_outputs got %b want 000000",
                {bus.Mode, bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDOEn, bus.TDO});
        end
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        checks++; if (bus.TapState !== 4'h2) begin errors++; $display("FAIL reach_shiftdr got %h want 2", bus.TapState); end
        rst = 1'b1; step(0, 0); rst = 1'b0;
        checks++; if (bus.TapState !== 4'hF) begin errors++; $display("FAIL rst_state got %h want F", bus.TapState); end
        checks++; if (bus.Instr !== RESET_OP) begin errors++; $display("FAIL rst_instr got %h want %h", bus.Instr, RESET_OP); end
        checks++; if ({bus.Mode, bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDOEn, bus.TDO} !== 6'b0) begin
            errors++; $display("FAIL rst_outputs got %b want 000000",
                {bus.Mode, bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDOEn, bus.TDO});
        end
    endtask

    task automatic test_all_states();
        logic [7:0] path [16];
        int         plen [16];
        path[4'h0] = 8'b0101010;  plen[4'h0] = 6;
        path[4'h1] = 8'b1010;     plen[4'h1] = 4;
        path[4'h2] = 8'b0010;     plen[4'h2] = 4;
        path[4'h3] = 8'b01010;    plen[4'h3] = 5;
        path[4'h4] = 8'b110;      plen[4'h4] = 3;
        path[4'h5] = 8'b11010;    plen[4'h5] = 5;
        path[4'h6] = 8'b010;      plen[4'h6] = 3;
        path[4'h7] = 8'b10;       plen[4'h7] = 2;
        path[4'h8] = 8'b1010110;  plen[4'h8] = 7;
        path[4'h9] = 8'b10110;    plen[4'h9] = 5;
        path[4'hA] = 8'b00110;    plen[4'hA] = 5;
        path[4'hB] = 8'b010110;   plen[4'hB] = 6;
        path[4'hC] = 8'b0;        plen[4'hC] = 1;
        path[4'hD] = 8'b110110;   plen[4'hD] = 6;
        path[4'hE] = 8'b0110;     plen[4'hE] = 4;
        path[4'hF] = 8'b0;        plen[4'hF] = 0;
        for (int s = 0; s < 16; s++) begin
            go_tlr();
            for (int k = 0; k < plen[s]; k++) step(path[s][k], 0);
            checks++; if (bus.TapState !== 4'(s)) begin errors++; $display("FAIL walk_to_state got %h want %h", bus.TapState, 4'(s)); end
            go_tlr();
            checks++; if (bus.TapState !== 4'hF) begin errors++; $display("FAIL tms5_from_%h got %h want F", 4'(s), bus.TapState); end
        end
    endtask

    task automatic test_load_extest();
        logic [3:0] exp_tdo;
        exp_tdo = 4'b0101;
        go_tlr();
        step(0, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        checks++; if (bus.TapState !== 4'hA) begin errors++; $display("FAIL reach_shiftir got %h want A", bus.TapState); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.TDO !== exp_tdo[i] || bus.TDOEn !== 1'b1) begin
                errors++; $display("FAIL ir_tdo bit %0d got tdo=%b en=%b want tdo=%b en=1", i, bus.TDO, bus.TDOEn, exp_tdo[i]);
            end
            step(i == 3, 1'b0);
        end
        checks++; if (bus.TapState !== 4'h9) begin errors++; $display("FAIL exit1ir got %h want 9", bus.TapState); end
        step(1, 0);
        checks++; if (bus.Instr !== RESET_OP || bus.Mode !== 1'b0) begin
            errors++; $display("FAIL instr_in_updir got %h/%b want %h/0", bus.Instr, bus.Mode, RESET_OP);
        end
        step(0, 0);
        checks++; if (bus.Instr !== 4'b0000 || bus.Mode !== 1'b1) begin
            errors++; $display("FAIL extest_loaded got %h/%b want 0/1", bus.Instr, bus.Mode);
        end
    endtask

    task automatic test_extest_dr();
        logic bsr;
        step(1, 0); step(0, 0);
        checks++; if ({bus.ClockDR, bus.ShiftDR, bus.UpdateDR} !== 3'b100) begin
            errors++; $display("FAIL capdr_ctrl got %b want 100", {bus.ClockDR, bus.ShiftDR, bus.UpdateDR});
        end
        step(0, 0);
        for (int i = 0; i < 51; i++) begin
            bsr = ((i % 3) == 0) ^ ((i % 7) == 2);
            bus.BsrTDO = bsr;
            #1;
            checks++; if ({bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDO, bus.Mode} !== {3'b110, bsr, 1'b1}) begin
                errors++; $display("FAIL shiftdr_cycle %0d got %b want %b", i,
                    {bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDO, bus.Mode}, {3'b110, bsr, 1'b1});
            end
            step(i == 50, 0);
        end
        checks++; if (bus.TapState !== 4'h1) begin errors++; $display("FAIL exit1dr got %h want 1", bus.TapState); end
        step(0, 0);
        checks++; if ({bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDO} !== 4'b0) begin
            errors++; $display("FAIL pausedr_ctrl got %b want 0000", {bus.ShiftDR, bus.ClockDR, bus.UpdateDR, bus.TDO});
        end
        step(1, 0);
        checks++; if (bus.UpdateDR !== 1'b0) begin errors++; $display("FAIL exit2dr_upd got %b want 0", bus.UpdateDR); end
        step(1, 0);
        checks++; if (bus.UpdateDR !== 1'b1 || bus.ClockDR !== 1'b0) begin
            errors++; $display("FAIL updatedr_pulse got upd=%b clk=%b want 1/0", bus.UpdateDR, bus.ClockDR);
        end
        step(0, 0);
        checks++; if (bus.UpdateDR !== 1'b0) begin errors++; $display("FAIL updatedr_width got %b want 0", bus.UpdateDR); end
    endtask

    task automatic test_reset_midscan();
        step(1, 0); step(0, 0); step(0, 0);
        checks++; if (bus.ShiftDR !== 1'b1 || bus.Mode !== 1'b1) begin
            errors++; $display("FAIL midscan_pre got sh=%b mode=%b want 1/1", bus.ShiftDR, bus.Mode);
        end
        rst = 1'b1; step(0, 1); rst = 1'b0;
        checks++; if ({bus.TapState, bus.Mode, bus.UpdateDR, bus.ShiftDR} !== {4'hF, 3'b000}) begin
            errors++; $display("FAIL midscan_rst got st=%h mode=%b upd=%b sh=%b want F/0/0/0",
                bus.TapState, bus.Mode, bus.UpdateDR, bus.ShiftDR);
        end
        checks++; if (bus.Instr !== RESET_OP) begin errors++; $display("FAIL midscan_instr got %h want %h", bus.Instr, RESET_OP); end
        step(1, 0);
        checks++; if (bus.UpdateDR !== 1'b0 || bus.TapState !== 4'hF) begin
            errors++; $display("FAIL midscan_after got upd=%b st=%h want 0/F", bus.UpdateDR, bus.TapState);
        end
    endtask

    task automatic test_bypass();
        logic [8:0] tdi_seq;
        logic       prev;
        tdi_seq = 9'b0_0100_1101;
        go_tlr(); step(0, 0);
        load_ir(4'b1111);
        checks++; if (bus.Instr !== 4'hF || bus.Mode !== 1'b0) begin
            errors++; $display("FAIL bypass_loaded got %h/%b want F/0", bus.Instr, bus.Mode);
        end
        step(1, 0); step(0, 0);
        checks++; if (bus.ClockDR !== 1'b0) begin errors++; $display("FAIL bypass_capdr got %b want 0", bus.ClockDR); end
        step(0, 0);
        prev = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bus.BsrTDO = 1'b1;
            #1;
            checks++; if ({bus.TDO, bus.ShiftDR, bus.ClockDR, bus.TDOEn} !== {prev, 3'b001}) begin
                errors++; $display("FAIL bypass_cycle %0d got %b want %b", i,
                    {bus.TDO, bus.ShiftDR, bus.ClockDR, bus.TDOEn}, {prev, 3'b001});
            end
            step(i == 8, tdi_seq[i]);
            prev = tdi_seq[i];
        end
        step(1, 0);
        checks++; if (bus.TapState !== 4'h5 || bus.UpdateDR !== 1'b0) begin
            errors++; $display("FAIL bypass_update got st=%h upd=%b want 5/0", bus.TapState, bus.UpdateDR);
        end
        step(0, 0);
    endtask

    task automatic test_idcode();
        logic tdi;
        logic exp;
        logic prev;
        rst = 1'b1; step(1, 0); rst = 1'b0;
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        prev = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tdi = (i[0] ^ i[2]) | (i == 31);
`ifdef TAP_IDCODE_EN
            exp = ID_VAL[i];
`else
            exp = prev;
`endif
            checks++; if (bus.TDO !== exp) begin
                errors++; $display("FAIL idcode_bit %0d got %b want %b", i, bus.TDO, exp);
            end
            step(i == 31, tdi);
            prev = tdi;
        end
        step(1, 0); step(0, 0);
        checks++; if (bus.TapState !== 4'hC || bus.Instr !== RESET_OP) begin
            errors++; $display("FAIL idcode_end got st=%h instr=%h want C/%h", bus.TapState, bus.Instr, RESET_OP);
        end
    endtask

    initial begin
        bus.TMS    = 1'b1;
        bus.TDI    = 1'b0;
        bus.BsrTDO = 1'b0;
        rst = 1'b1;
        step(1, 0); step(1, 0);
        rst = 1'b0;
        test_reset();
        test_all_states();
        test_load_extest();
        test_extest_dr();
        test_reset_midscan();
        test_bypass();
        test_idcode();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
